// File: rtl/dram_wr_arbiter.sv
// Two-requester round-robin arbiter that serializes whole write bursts onto one DRAM data/command port pair.
// Optional burst statistics counters are built only when DWARB_STATS_EN is defined.
module dram_wr_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  s_ctrl_valid,
  input  logic [79:0] s_ctrl,
  output logic [1:0]  s_ctrl_ready,
  input  logic [1:0]  s_data_valid,
  input  logic [71:0] s_data,
  output logic [1:0]  s_data_ready,
  output logic [35:0] data_in,
  output logic        data_we,
  input  logic        dn_data_ready,
  output logic [39:0] ctrl_in,
  output logic        ctrl_we,
  input  logic        dn_ctrl_ready,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [15:0] stat_bursts0,
  output logic [15:0] stat_bursts1
);
  typedef enum logic [1:0] {IDLE, DATA, CTRL, DONE} state_t;

  state_t      state;
  logic        last_grant;
  logic [39:0] cmd;
  logic [8:0]  cnt;
  logic        win;
  logic [39:0] win_cmd;
  logic [35:0] word;
  logic        beat;

  // On a tie the requester that did not own the previous burst wins
  assign win     = (&s_ctrl_valid) ? ~last_grant : s_ctrl_valid[1];
  assign win_cmd = win ? s_ctrl[79:40] : s_ctrl[39:0];
  assign word    = grant[1] ? s_data[71:36] : s_data[35:0];

  // Pop strobes are gated by rst so every output reads 0 the instant reset rises
  assign s_ctrl_ready = (!rst && state == IDLE && |s_ctrl_valid) ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign s_data_ready = (!rst && state == DATA && dn_data_ready) ? grant : 2'b00;
  assign beat         = |(s_data_ready & s_data_valid);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 2'b00;
      cmd        <= '0;
      cnt        <= '0;
      data_in    <= '0;
      data_we    <= 1'b0;
      ctrl_in    <= '0;
      ctrl_we    <= 1'b0;
    end else begin
      data_we <= 1'b0;
      ctrl_we <= 1'b0;
      case (state)
        IDLE: if (|s_ctrl_valid) begin
          cmd   <= win_cmd;
          // len==0 encodes a 256-word burst
          cnt   <= {win_cmd[39:32] == 8'd0, win_cmd[39:32]};
          grant <= win ? 2'b10 : 2'b01;
          state <= DATA;
        end
        DATA: if (beat) begin
          data_in <= word;
          data_we <= 1'b1;
          cnt     <= cnt - 9'd1;
          if (cnt == 9'd1) state <= CTRL;
        end
        CTRL: if (dn_ctrl_ready) begin
          ctrl_in <= cmd;
          ctrl_we <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          last_grant <= grant[1];
          grant      <= 2'b00;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DWARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_bursts0 <= '0;
      stat_bursts1 <= '0;
    end else if (state == DONE) begin
      if (grant[0] && stat_bursts0 != 16'hFFFF) stat_bursts0 <= stat_bursts0 + 16'd1;
      if (grant[1] && stat_bursts1 != 16'hFFFF) stat_bursts1 <= stat_bursts1 + 16'd1;
    end
  end
`else
  assign stat_bursts0 = 16'h0000;
  assign stat_bursts1 = 16'h0000;
`endif

endmodule

// File: tb/tb_dram_wr_arbiter.sv
// Bench for dram_wr_arbiter: requester FIFOs are modelled as queues, the expected burst order and
// word/command streams are derived up front from the round-robin rules and compared as the DUT emits them.
module tb_dram_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  s_ctrl_valid = '0, s_data_valid = '0;
  logic [79:0] s_ctrl = '0;
  logic [71:0] s_data = '0;
  logic        dn_data_ready = 1'b1, dn_ctrl_ready = 1'b1;
  logic [1:0]  s_ctrl_ready, s_data_ready, grant;
  logic [35:0] data_in;
  logic        data_we, ctrl_we, busy;
  logic [39:0] ctrl_in;
  logic [15:0] stat_bursts0, stat_bursts1;

  int total = 0, fails = 0;
  logic [39:0] cq0[$], cq1[$];
  logic [35:0] dq0[$], dq1[$];
  logic [39:0] exp_ctrl[$];
  logic [35:0] exp_data[$];
  int          exp_req[$], exp_len[$];
  int          m_last = 1;
  int          done_cnt[2];

  dram_wr_arbiter dut (
    .clk(clk), .rst(rst),
    .s_ctrl_valid(s_ctrl_valid), .s_ctrl(s_ctrl), .s_ctrl_ready(s_ctrl_ready),
    .s_data_valid(s_data_valid), .s_data(s_data), .s_data_ready(s_data_ready),
    .data_in(data_in), .data_we(data_we), .dn_data_ready(dn_data_ready),
    .ctrl_in(ctrl_in), .ctrl_we(ctrl_we), .dn_ctrl_ready(dn_ctrl_ready),
    .grant(grant), .busy(busy),
    .stat_bursts0(stat_bursts0), .stat_bursts1(stat_bursts1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, {s_ctrl_ready, s_data_ready}, 64'h0);
    chk({tag, "_data"},  {data_we, data_in}, 64'h0);
    chk({tag, "_ctrl"},  {ctrl_we, ctrl_in}, 64'h0);
    chk({tag, "_grant"}, {busy, grant}, 64'h0);
    chk({tag, "_stats"}, {stat_bursts1, stat_bursts0}, 64'h0);
  endtask

  task automatic chk_stats();
`ifdef DWARB_STATS_EN
    chk("stat_bursts0", stat_bursts0, done_cnt[0]);
    chk("stat_bursts1", stat_bursts1, done_cnt[1]);
`else
    chk("stat_bursts0", stat_bursts0, 64'h0);
    chk("stat_bursts1", stat_bursts1, 64'h0);
`endif
  endtask

  task automatic flush();
    cq0.delete(); cq1.delete(); dq0.delete(); dq1.delete();
    exp_ctrl.delete(); exp_data.delete(); exp_req.delete(); exp_len.delete();
    m_last = 1;
    done_cnt = '{0, 0};
  endtask

  // Valid inputs are held high during reset to show the pop strobes stay quiet
  task automatic do_reset();
    rst = 1'b1;
    s_ctrl_valid = '1; s_ctrl = '1; s_data_valid = '1; s_data = '1;
    dn_data_ready = 1'b1; dn_ctrl_ready = 1'b1;
    flush();
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 chk_zero("reset_hold");
    s_ctrl_valid = '0; s_data_valid = '0;
    rst = 1'b0;
  endtask

  task automatic add_cmd(input int r, input int len, input logic [31:0] addr);
    logic [39:0] c;
    int n;
    c = {8'(len), addr};
    n = (len % 256 == 0) ? 256 : len;
    if (r == 0) cq0.push_back(c); else cq1.push_back(c);
    repeat (n) begin
      logic [35:0] w;
      w = {4'($urandom), 32'($urandom)};
      if (r == 0) dq0.push_back(w); else dq1.push_back(w);
    end
  endtask

  // Reference: with all commands queued up front, bursts are served alternately while both
  // requesters have work, then the remaining one drains; each burst emits its words then its command.
  task automatic build();
    logic [39:0] c0[$], c1[$];
    logic [35:0] d0[$], d1[$];
    c0 = cq0; c1 = cq1; d0 = dq0; d1 = dq1;
    while (c0.size() != 0 || c1.size() != 0) begin
      int r, n;
      logic [39:0] c;
      if (c0.size() != 0 && c1.size() != 0) r = 1 - m_last;
      else r = (c0.size() != 0) ? 0 : 1;
      m_last = r;
      c = (r == 1) ? c1.pop_front() : c0.pop_front();
      n = (c[39:32] == 8'd0) ? 256 : int'(c[39:32]);
      exp_req.push_back(r); exp_ctrl.push_back(c); exp_len.push_back(n);
      repeat (n) exp_data.push_back((r == 1) ? d1.pop_front() : d0.pop_front());
    end
  endtask

  // timed (rnd=0) runs also check latency/cost; extra = directed stall cycles expected in one burst
  task automatic run(input int budget, input bit rnd, input int dstall_after, input int cstall,
                     input int extra, input int abort_after);
    int cyc = 0, bw = 0, pop_edge = 0, last_pop = -1, prev_len = 0, cur_len = 0, cur_req = 0;
    int dlow = 0, clow = 0, npops = 0, nb;
    bit d_done = 0, c_done = 0, cr_prev = 1, grant_due = 0;
    bit [1:0] popc = 0, popd = 0, g_exp = 0;
    nb = exp_ctrl.size();
    while ((exp_ctrl.size() != 0 || busy) && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (popc[0]) void'(cq0.pop_front());
      if (popc[1]) void'(cq1.pop_front());
      if (popd[0]) void'(dq0.pop_front());
      if (popd[1]) void'(dq1.pop_front());
      if (grant_due) begin
        chk("grant", {busy, grant}, {1'b1, g_exp});
        grant_due = 0;
      end
      chk("data_we_follows_pop", data_we, |popd);
      chk("we_exclusive", data_we & ctrl_we, 64'h0);
      if (data_we) begin
        if (exp_data.size() == 0) chk("data_extra", data_in, 64'h0 - 64'h1);
        else chk("data_word", data_in, exp_data.pop_front());
        bw++;
        if (abort_after > 0 && bw == abort_after) begin
          rst = 1'b1;
          #1 chk_zero("abort");
          return;
        end
      end
      if (ctrl_we) begin
        chk("ctrl_after_words", bw, cur_len);
        chk("ctrl_ready_prev", cr_prev, 64'h1);
        if (exp_ctrl.size() == 0) chk("ctrl_extra", ctrl_in, 64'h0 - 64'h1);
        else chk("ctrl_word", ctrl_in, exp_ctrl.pop_front());
        if (!rnd) chk("ctrl_latency", cyc - pop_edge, cur_len + 1 + extra);
        done_cnt[cur_req]++;
        bw = 0;
      end
      if (!d_done && dstall_after > 0 && bw == dstall_after) begin dlow = 5; d_done = 1; end
      if (!c_done && cstall > 0 && cur_len > 0 && bw == cur_len) begin clow = cstall; c_done = 1; end
      s_ctrl_valid = {cq1.size() != 0, cq0.size() != 0};
      s_ctrl = {(cq1.size() != 0) ? cq1[0] : 40'h0, (cq0.size() != 0) ? cq0[0] : 40'h0};
      s_data_valid[0] = dq0.size() != 0 && (!rnd || $urandom_range(0, 3) != 0);
      s_data_valid[1] = dq1.size() != 0 && (!rnd || $urandom_range(0, 3) != 0);
      s_data = {(dq1.size() != 0) ? dq1[0] : 36'h0, (dq0.size() != 0) ? dq0[0] : 36'h0};
      dn_data_ready = (dlow == 0) && (!rnd || $urandom_range(0, 3) != 0);
      dn_ctrl_ready = (clow == 0) && (!rnd || $urandom_range(0, 2) != 0);
      if (dlow > 0) dlow--;
      if (clow > 0) clow--;
      cr_prev = dn_ctrl_ready;
      #1;
      popc = s_ctrl_ready & s_ctrl_valid;
      popd = s_data_ready & s_data_valid;
      chk("data_pop_owner", s_data_ready & ~grant, 64'h0);
      if (s_ctrl_ready != 2'b00) begin
        chk("arb_pick", s_ctrl_ready, (exp_req.size() != 0) ? (64'h1 << exp_req[0]) : 64'h0);
        if (exp_req.size() != 0) cur_req = exp_req.pop_front();
        pop_edge = cyc + 1;
        npops++;
        if (!rnd && extra == 0 && last_pop >= 0) chk("burst_cost", pop_edge - last_pop, prev_len + 3);
        last_pop = pop_edge;
        cur_len = (exp_len.size() != 0) ? exp_len.pop_front() : 0;
        prev_len = cur_len;
        g_exp = s_ctrl_ready;
        grant_due = 1;
      end
    end
    chk("drained_cmds", exp_ctrl.size(), 64'h0);
    chk("drained_words", exp_data.size(), 64'h0);
    chk("ctrl_pops", npops, nb);
  endtask

  initial begin
    #1;
    do_reset();

    // single burst, requester 0
    add_cmd(0, 4, 32'h0000_0100);
    build();
    run(100, 0, 0, 0, 0, 0);

    // round-robin from reset: 0,1,0,1,0,1
    do_reset();
    repeat (3) begin
      add_cmd(0, 2, $urandom);
      add_cmd(1, 2, $urandom);
    end
    build();
    run(200, 0, 0, 0, 0, 0);

    // 5-cycle data stall after 3 words, then 3-cycle command stall
    add_cmd(0, 8, 32'h0000_3000);
    build();
    run(200, 0, 3, 3, 8, 0);

    // len=0 carries 256 words and passes len through unchanged
    add_cmd(1, 0, 32'h0000_2000);
    build();
    run(400, 0, 0, 0, 0, 0);

    // reset after 3 of 8 beats, then both request: requester 0 first
    add_cmd(0, 8, 32'h0000_4000);
    build();
    run(100, 0, 0, 0, 0, 3);
    flush();
    s_ctrl_valid = '0; s_data_valid = '0;
    @(posedge clk); #1;
    chk_zero("abort_hold");
    rst = 1'b0;
    add_cmd(1, 2, 32'h0000_5100);
    add_cmd(0, 2, 32'h0000_5000);
    build();
    run(100, 0, 0, 0, 0, 0);

    // statistics: 3 bursts from requester 0, 1 from requester 1
    do_reset();
    repeat (3) add_cmd(0, $urandom_range(1, 4), $urandom);
    add_cmd(1, $urandom_range(1, 4), $urandom);
    build();
    run(200, 0, 0, 0, 0, 0);
    chk_stats();

    // randomized gaps and backpressure
    repeat (14) add_cmd($urandom_range(0, 1), $urandom_range(1, 9), $urandom);
    build();
    run(3000, 1, 0, 0, 0, 0);
    chk_stats();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
